hsid_x_obi_mem: RTL and testbench

OBI responder memory that serves the HSID-X OBI read initiator: stores captured and library hyperspectral pixels as packed 32-bit words, two 16-bit bands per word. It accepts pipelined OBI read and write requests. It answers them in order through a response buffer with backpressure. It zero-initialises itself after reset. It sits on the bus between the HSID-X accelerator and the testbench/host loader.

---
 rtl/hsid_pkg.sv | 19 +
 rtl/hsid_fifo.sv | 58 +++++
 rtl/hsid_x_obi_mem.sv | 155 +++++++++++++++
 tb/tb_hsid_x_obi_mem.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hsid_pkg.sv
// Shared types and constants for the HSID-X blocks.
// Holds the OBI memory FSM states and the response record kept in its buffer.
package hsid_pkg;

    localparam int unsigned HSID_WORD_WIDTH         = 32;
    localparam int unsigned HSID_BUFFER_WIDTH       = 2;
    localparam int unsigned HSID_OBI_MEM_ADDR_WIDTH = 8;

    typedef enum logic [0:0] {
        MEM_CLEAR,
        MEM_READY
    } hsid_obi_mem_state_t;

    typedef struct packed {
        logic                       err;
        logic [HSID_WORD_WIDTH-1:0] rdata;
    } hsid_obi_rsp_t;

endpackage

// File: rtl/hsid_fifo.sv
// Synchronous first-word-fall-through FIFO; data_o shows the head entry whenever empty_o is low.
// Pushes while full and pops while empty are ignored.
module hsid_fifo #(
    parameter int unsigned DATA_WIDTH   = 33,
    parameter int unsigned BUFFER_WIDTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned DEPTH = 2 ** BUFFER_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [BUFFER_WIDTH:0] r_wptr;
    logic [BUFFER_WIDTH:0] r_rptr;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[BUFFER_WIDTH] != r_rptr[BUFFER_WIDTH]) &&
                     (r_wptr[BUFFER_WIDTH-1:0] == r_rptr[BUFFER_WIDTH-1:0]);
    assign w_push  = push_i && !w_full;
    assign w_pop   = pop_i && !w_empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr[BUFFER_WIDTH-1:0]] <= data_i;
        end
    end

    assign data_o  = r_mem[r_rptr[BUFFER_WIDTH-1:0]];
    assign full_o  = w_full;
    assign empty_o = w_empty;

endmodule

// File: rtl/hsid_x_obi_mem.sv
// OBI responder memory holding packed 16-bit band pairs for the HSID-X read initiator.
// Zero-fills itself after reset, then serves pipelined reads/writes in order through a buffer.
module hsid_x_obi_mem
    import hsid_pkg::*;
#(
    parameter int unsigned WORD_WIDTH   = HSID_WORD_WIDTH,
    parameter int unsigned ADDR_WIDTH   = HSID_OBI_MEM_ADDR_WIDTH,
    parameter int unsigned BUFFER_WIDTH = HSID_BUFFER_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    obi_req_i,
    output logic                    obi_gnt_o,
    input  logic [31:0]             obi_addr_i,
    input  logic                    obi_we_i,
    input  logic [WORD_WIDTH/8-1:0] obi_be_i,
    input  logic [WORD_WIDTH-1:0]   obi_wdata_i,
    output logic                    obi_rvalid_o,
    input  logic                    obi_rready_i,
    output logic [WORD_WIDTH-1:0]   obi_rdata_o,
    output logic                    obi_err_o,
    output logic                    init_done_o
);

    localparam int unsigned   DEPTH   = 2 ** ADDR_WIDTH;
    localparam int unsigned   RSP_W   = $bits(hsid_obi_rsp_t);
    localparam logic [BUFFER_WIDTH:0] MAX_OUT = (BUFFER_WIDTH + 1)'(2 ** BUFFER_WIDTH);

    hsid_obi_mem_state_t   r_state;
    logic                  r_init_done;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic [BUFFER_WIDTH:0] r_outstanding;

    logic [WORD_WIDTH-1:0] r_mem [DEPTH];
    logic [WORD_WIDTH-1:0] r_mem_rdata;
    logic                  r_stage_valid;
    logic                  r_stage_err;
    logic                  r_stage_we;

    logic                  w_gnt;
    logic                  w_accept;
    logic                  w_err;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_retire;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    hsid_obi_rsp_t         w_push_rsp;
    hsid_obi_rsp_t         w_head_rsp;
    logic [RSP_W-1:0]      w_head_bits;

    assign w_gnt    = (r_state == MEM_READY) && (r_outstanding < MAX_OUT);
    assign w_accept = obi_req_i && w_gnt;
    assign w_idx    = obi_addr_i[ADDR_WIDTH+1:2];
    assign w_err    = (obi_addr_i[1:0] != 2'b00) || (obi_addr_i[31:ADDR_WIDTH+2] != '0);
    assign w_retire = !w_fifo_empty && obi_rready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= MEM_CLEAR;
            r_init_done <= 1'b0;
            r_clr_cnt   <= '0;
        end else begin
            case (r_state)
                MEM_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == '1) begin
                        r_state     <= MEM_READY;
                        r_init_done <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= MEM_READY;
                    r_init_done <= 1'b1;
                end
            endcase
        end
    end

    // Erroneous requests never touch the array; reads still load the port so the
    // stage has a defined source, but the response forces rdata to zero.
    always_ff @(posedge clk_i) begin
        if (r_state == MEM_CLEAR) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_accept && obi_we_i && !w_err) begin
            for (int b = 0; b < WORD_WIDTH / 8; b++) begin
                if (obi_be_i[b]) begin
                    r_mem[w_idx][8*b +: 8] <= obi_wdata_i[8*b +: 8];
                end
            end
        end
        if (w_accept && !obi_we_i) begin
            r_mem_rdata <= r_mem[w_idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stage_valid <= 1'b0;
            r_stage_err   <= 1'b0;
            r_stage_we    <= 1'b0;
        end else begin
            r_stage_valid <= w_accept;
            r_stage_err   <= w_err;
            r_stage_we    <= obi_we_i;
        end
    end

    // Counts stage plus buffer occupancy, so capping it at the buffer depth
    // guarantees every staged response finds a free slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_outstanding <= '0;
        end else begin
            case ({w_accept, w_retire})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && r_stage_valid) begin
            assert (!w_fifo_full);
        end
    end

    always_comb begin
        w_push_rsp       = '0;
        w_push_rsp.err   = r_stage_err;
        w_push_rsp.rdata = (r_stage_err || r_stage_we) ? '0 : r_mem_rdata;
    end

    hsid_fifo #(
        .DATA_WIDTH  (RSP_W),
        .BUFFER_WIDTH(BUFFER_WIDTH)
    ) u_rsp_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (r_stage_valid),
        .data_i (w_push_rsp),
        .pop_i  (obi_rready_i),
        .data_o (w_head_bits),
        .full_o (w_fifo_full),
        .empty_o(w_fifo_empty)
    );

    assign w_head_rsp   = hsid_obi_rsp_t'(w_head_bits);
    assign obi_gnt_o    = w_gnt;
    assign obi_rvalid_o = !w_fifo_empty;
    assign obi_rdata_o  = w_fifo_empty ? '0 : w_head_rsp.rdata;
    assign obi_err_o    = w_fifo_empty ? 1'b0 : w_head_rsp.err;
    assign init_done_o  = r_init_done;

endmodule

// File: tb/tb_hsid_x_obi_mem.sv
// Directed bench for hsid_x_obi_mem: vector table for single transactions plus
// hand-written backpressure, streaming and mid-operation reset sequences.
module tb_hsid_x_obi_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        gnt;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] rdata;
    logic        err;
    logic        init_done;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hsid_x_obi_mem dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .obi_req_i   (req),
        .obi_gnt_o   (gnt),
        .obi_addr_i  (addr),
        .obi_we_i    (we),
        .obi_be_i    (be),
        .obi_wdata_i (wdata),
        .obi_rvalid_o(rvalid),
        .obi_rready_i(rready),
        .obi_rdata_o (rdata),
        .obi_err_o   (err),
        .init_done_o (init_done)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic xact(input logic t_we, input logic [31:0] t_addr, input logic [3:0] t_be,
                        input logic [31:0] t_wdata, output logic [31:0] o_rd, output logic o_er,
                        output int o_lat);
        int w;
        req = 1'b1; we = t_we; addr = t_addr; be = t_be; wdata = t_wdata; rready = 1'b1;
        w = 0;
        while (!gnt && w < 50) begin
            step();
            w++;
        end
        chk("xact_gnt", 32'(gnt), 32'd1);
        step();
        req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
        o_lat = 1;
        while (!rvalid && o_lat < 20) begin
            step();
            o_lat++;
        end
        o_rd = rdata;
        o_er = err;
        step();
    endtask

    // Counts cycles with gnt low after reset release; rvalid must stay low throughout.
    task automatic count_clear(input string name);
        int n;
        int stale;
        n = 0;
        stale = 0;
        while (!gnt && n < 400) begin
            if (rvalid) stale++;
            n++;
            step();
        end
        chk({name, "_len"}, 32'(n), 32'd256);
        chk({name, "_stale"}, 32'(stale), 32'd0);
        chk({name, "_init_done"}, 32'(init_done), 32'd1);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] stream_val[16];
    logic [31:0] bp_val[6];
    int          issued, got, first_rv, last_rv, out_m, max_out, cyc4, gnt_drop;
    logic        acc, ret;

    initial begin
        vecs[0]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,          1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h0000_0008, 4'hF, 32'h1234_ABCD,  1'b0, 32'h0};
        vecs[2]  = '{1'b1, 32'h0000_0008, 4'h1, 32'h0000_00EE,  1'b0, 32'h0};
        vecs[3]  = '{1'b0, 32'h0000_0008, 4'h0, 32'h0,          1'b0, 32'h1234_ABEE};
        vecs[4]  = '{1'b0, 32'h0000_0002, 4'h0, 32'h0,          1'b1, 32'h0};
        vecs[5]  = '{1'b1, 32'h0000_0400, 4'hF, 32'hFFFF_FFFF,  1'b1, 32'h0};
        vecs[6]  = '{1'b0, 32'h0000_0000, 4'h0, 32'h0,          1'b0, 32'h0};
        vecs[7]  = '{1'b1, 32'h0000_03FC, 4'hC, 32'hA5A5_5A5A,  1'b0, 32'h0};
        vecs[8]  = '{1'b0, 32'h0000_03FC, 4'h0, 32'h0,          1'b0, 32'hA5A5_0000};
        vecs[9]  = '{1'b1, 32'h0000_0004, 4'h6, 32'hDEAD_BEEF,  1'b0, 32'h0};
        vecs[10] = '{1'b0, 32'h0000_0004, 4'h0, 32'h0,          1'b0, 32'h00AD_BE00};
        vecs[11] = '{1'b0, 32'h8000_0000, 4'h0, 32'h0,          1'b1, 32'h0};
        vecs[12] = '{1'b1, 32'h0000_0001, 4'hF, 32'h1111_1111,  1'b1, 32'h0};
        vecs[13] = '{1'b0, 32'h0000_0000, 4'h0, 32'h0,          1'b0, 32'h0};
        for (int k = 0; k < 16; k++) stream_val[k] = {16'(k + 1), 16'(k)};
        for (int k = 0; k < 6; k++) bp_val[k] = 32'hB000_0000 + 32'(k) * 32'h1111;

        // Reset and clear
        step();
        step();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        rst = 1'b0;
        count_clear("clear");

        // Single transactions, latency must be exactly two cycles
        foreach (vecs[i]) begin
            xact(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd2);
        end

        // Streaming with rready held high
        for (int k = 0; k < 16; k++) xact(1'b1, 32'h40 + 32'(4 * k), 4'hF, stream_val[k], rd, er, lat);
        issued = 0; got = 0; first_rv = -1; last_rv = -1; out_m = 0; max_out = 0;
        rready = 1'b1;
        for (int c = 0; c < 60 && got < 16; c++) begin
            ret = rvalid;
            if (rvalid) begin
                chk($sformatf("stream%0d", got), rdata, stream_val[got]);
                if (first_rv < 0) first_rv = c;
                last_rv = c;
                got++;
            end
            acc = 1'b0;
            if (issued < 16) begin
                req = 1'b1; we = 1'b0; addr = 32'h40 + 32'(4 * issued);
                acc = gnt;
                if (gnt) issued++;
            end else begin
                req = 1'b0;
            end
            out_m = out_m + int'(acc) - int'(ret);
            if (out_m > max_out) max_out = out_m;
            step();
        end
        req = 1'b0;
        chk("stream_count", 32'(got), 32'd16);
        chk("stream_span", 32'(last_rv - first_rv + 1), 32'd16);
        chk("stream_max_out", 32'(max_out <= 2), 32'd1);

        // Backpressure: only four accepted with rready low
        for (int k = 0; k < 6; k++) xact(1'b1, 32'h80 + 32'(4 * k), 4'hF, bp_val[k], rd, er, lat);
        rready = 1'b0; issued = 0; cyc4 = -1; gnt_drop = -1;
        for (int c = 0; c < 10; c++) begin
            if (issued < 6) begin
                req = 1'b1; we = 1'b0; addr = 32'h80 + 32'(4 * issued);
            end else begin
                req = 1'b0;
            end
            if (!gnt && issued == 4 && gnt_drop < 0) gnt_drop = c;
            if (req && gnt) begin
                issued++;
                if (issued == 4) cyc4 = c;
            end
            step();
        end
        chk("bp_granted", 32'(issued), 32'd4);
        chk("bp_gnt_drop", 32'(gnt_drop), 32'(cyc4 + 1));
        chk("bp_held_rvalid", 32'(rvalid), 32'd1);
        chk("bp_held_rdata", rdata, bp_val[0]);
        rready = 1'b1;
        step();
        rready = 1'b0;
        chk("bp_gnt_rise", 32'(gnt), 32'd1);
        chk("bp_next_rdata", rdata, bp_val[1]);
        if (gnt) issued++;
        step();
        got = 1;
        rready = 1'b1;
        for (int c = 0; c < 40 && got < 6; c++) begin
            if (rvalid) begin
                chk($sformatf("bp_order%0d", got), rdata, bp_val[got]);
                got++;
            end
            if (issued < 6) begin
                req = 1'b1; we = 1'b0; addr = 32'h80 + 32'(4 * issued);
                if (gnt) issued++;
            end else begin
                req = 1'b0;
            end
            step();
        end
        req = 1'b0;
        chk("bp_drained", 32'(got), 32'd6);

        // Mid-operation reset with three responses pending
        rready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req = 1'b1; we = 1'b0; addr = 32'h80 + 32'(4 * k);
            step();
        end
        req = 1'b0;
        step();
        step();
        chk("mid_pending", 32'(rvalid), 32'd1);
        rst = 1'b1;
        rready = 1'b1;
        step();
        chk("mid_rvalid_flush", 32'(rvalid), 32'd0);
        chk("mid_init_done", 32'(init_done), 32'd0);
        step();
        rst = 1'b0;
        count_clear("reclear");
        xact(1'b0, 32'h0000_0008, 4'h0, 32'h0, rd, er, lat);
        chk("reclear_word2", rd, 32'h0);
        chk("reclear_err", 32'(er), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
